hamming_minmax_engine: RTL and testbench

Hardware accelerator for the min/max Hamming-distance workload, generalised in word width, word count and memory placement.
- Reads a run-time-sized array of multi-byte words from the byte-wide data memory.
- Evaluates every unordered pair and reports the minimum and maximum distances with the indices of the first pair achieving each.
- Writes the two distances back to memory.
- Sits beside the core on the data-memory port; the core starts it and polls done.

---
 rtl/hamming_minmax_engine_pkg.sv | 19 +
 rtl/hamming_minmax_engine_popcount.sv | 18 +
 rtl/hamming_minmax_engine.sv | 181 ++++++++++++++++++
 tb/tb_hamming_minmax_engine.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hamming_minmax_engine_pkg.sv
// Shared definitions for the min/max Hamming-distance engine.
//   state_t    : control FSM encoding
//   DEF_WORD_W : default operand width in bits
//   DEF_N_MAX  : default word-cache depth
package hamming_pkg;

    localparam int DEF_WORD_W = 16;
    localparam int DEF_N_MAX  = 32;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CMP,
        WB_MIN,
        WB_MAX,
        DONE
    } state_t;

endpackage

// File: rtl/hamming_minmax_engine_popcount.sv
// Combinational population count.
//   a   : W-bit operand
//   cnt : number of set bits in a, $clog2(W+1) bits wide
module popcount #(
    parameter  int W  = 16,
    localparam int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  a,
    output logic [CW-1:0] cnt
);

    always_comb begin
        cnt = '0;
        for (int k = 0; k < W; k++)
            cnt = cnt + CW'(a[k]);
    end

endmodule

// File: rtl/hamming_minmax_engine.sv
// Min/max Hamming-distance accelerator on the byte-wide data-memory port.
// Loads cfg_count words (MSB byte first) starting at cfg_base, compares all
// unordered pairs one per cycle, then writes min/max distances to cfg_res and
// cfg_res+1.
//   clk, reset     : clock, asynchronous active-low reset
//   start          : run request, honoured only in IDLE or DONE
//   cfg_base/count/res : run configuration, latched on an accepted start
//   busy, done     : status (done is sticky until the next accepted start)
//   mem_rd_*       : read port, data returns one cycle after the address
//   mem_wr_*       : write port used for the two result bytes
//   min_*/max_*    : final distances and the first pair achieving each
module hamming_minmax_engine
    import hamming_pkg::*;
#(
    parameter  int WORD_W = DEF_WORD_W,
    parameter  int N_MAX  = DEF_N_MAX,
    parameter  int ADDR_W = 8,
    localparam int DIST_W = $clog2(WORD_W + 1),
    localparam int IDX_W  = $clog2(N_MAX)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [IDX_W:0]    cfg_count,
    input  logic [ADDR_W-1:0] cfg_res,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [7:0]        mem_rd_data,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [7:0]        mem_wr_data,
    output logic [DIST_W-1:0] min_dist,
    output logic [DIST_W-1:0] max_dist,
    output logic [IDX_W-1:0]  min_i,
    output logic [IDX_W-1:0]  min_j,
    output logic [IDX_W-1:0]  max_i,
    output logic [IDX_W-1:0]  max_j
);

    localparam int B    = WORD_W / 8;
    localparam int LD_W = $clog2(B * N_MAX + 1) + 1;
    localparam int CB_W = $clog2(B + 1);

    typedef logic [IDX_W:0] cnt_t;

    state_t            state;
    logic [ADDR_W-1:0] base_q, res_q;
    cnt_t              count_q;
    logic [LD_W-1:0]   ld_cnt, ld_total;
    logic [CB_W-1:0]   cap_byte;
    logic [IDX_W-1:0]  cap_word;
    logic [IDX_W-1:0]  ci, cj;

    logic [WORD_W-1:0] cache [N_MAX];
    logic [WORD_W-1:0] cmp_x;
    logic [DIST_W-1:0] cmp_d;
    logic              last_j, last_i;

    assign ld_total = LD_W'(count_q) * LD_W'(B);
    assign last_j   = (cnt_t'(cj) == count_q - cnt_t'(1));
    assign last_i   = (cnt_t'(ci) == count_q - cnt_t'(2));

    assign cmp_x = cache[ci] ^ cache[cj];

    popcount #(.W(WORD_W)) u_pop (
        .a   (cmp_x),
        .cnt (cmp_d)
    );

    // Address is issued while ld_cnt < ld_total; the final LOAD cycle only
    // captures the last byte, so its address is a don't-care.
    assign mem_rd_addr = (state == LOAD) ? base_q + ADDR_W'(ld_cnt) : '0;

    // Write port decoded from state so reset removes it without waiting on clk.
    assign mem_wr_en   = (state == WB_MIN) || (state == WB_MAX);
    assign mem_wr_addr = (state == WB_MIN) ? res_q :
                         (state == WB_MAX) ? res_q + ADDR_W'(1) : '0;
    assign mem_wr_data = (state == WB_MIN) ? 8'(min_dist) :
                         (state == WB_MAX) ? 8'(max_dist) : '0;

    // Byte k of the load arrives during LOAD cycle k+1; bytes shift in MSB-first.
    always_ff @(posedge clk) begin
        if (state == LOAD && ld_cnt != '0)
            cache[cap_word] <= WORD_W'({cache[cap_word], mem_rd_data});
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            base_q   <= '0;
            res_q    <= '0;
            count_q  <= '0;
            ld_cnt   <= '0;
            cap_byte <= '0;
            cap_word <= '0;
            ci       <= '0;
            cj       <= '0;
            min_dist <= DIST_W'(WORD_W);
            max_dist <= '0;
            min_i    <= '0;
            min_j    <= '0;
            max_i    <= '0;
            max_j    <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state    <= LOAD;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        base_q   <= cfg_base;
                        res_q    <= cfg_res;
                        count_q  <= (cfg_count > cnt_t'(N_MAX)) ? cnt_t'(N_MAX) : cfg_count;
                        ld_cnt   <= '0;
                        cap_byte <= '0;
                        cap_word <= '0;
                        min_dist <= DIST_W'(WORD_W);
                        max_dist <= '0;
                        min_i    <= '0;
                        min_j    <= '0;
                        max_i    <= '0;
                        max_j    <= '0;
                    end
                end
                LOAD: begin
                    if (ld_cnt != '0) begin
                        if (cap_byte == CB_W'(B - 1)) begin
                            cap_byte <= '0;
                            cap_word <= cap_word + IDX_W'(1);
                        end else begin
                            cap_byte <= cap_byte + CB_W'(1);
                        end
                    end
                    if (ld_cnt == ld_total) begin
                        ci    <= '0;
                        cj    <= IDX_W'(1);
                        // Fewer than two words: no pairs, results stay at their init values.
                        state <= (count_q < cnt_t'(2)) ? WB_MIN : CMP;
                    end else begin
                        ld_cnt <= ld_cnt + LD_W'(1);
                    end
                end
                CMP: begin
                    // Strict compares keep the earliest pair on ties.
                    if (cmp_d < min_dist) begin
                        min_dist <= cmp_d;
                        min_i    <= ci;
                        min_j    <= cj;
                    end
                    if (cmp_d > max_dist) begin
                        max_dist <= cmp_d;
                        max_i    <= ci;
                        max_j    <= cj;
                    end
                    if (last_j) begin
                        if (last_i) begin
                            state <= WB_MIN;
                        end else begin
                            ci <= ci + IDX_W'(1);
                            cj <= ci + IDX_W'(2);
                        end
                    end else begin
                        cj <= cj + IDX_W'(1);
                    end
                end
                WB_MIN: state <= WB_MAX;
                WB_MAX: begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hamming_minmax_engine.sv
module tb_hamming_minmax_engine;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- DUT A: default 16-bit words, 32 deep ----------------
    logic       a_start, a_busy, a_done, a_wr_en;
    logic [7:0] a_base, a_res, a_rd_addr, a_rd_data, a_wr_addr, a_wr_data;
    logic [5:0] a_count;
    logic [4:0] a_min, a_max, a_mi, a_mj, a_xi, a_xj;

    hamming_minmax_engine dut_a (
        .clk(clk), .reset(reset), .start(a_start),
        .cfg_base(a_base), .cfg_count(a_count), .cfg_res(a_res),
        .busy(a_busy), .done(a_done),
        .mem_rd_addr(a_rd_addr), .mem_rd_data(a_rd_data),
        .mem_wr_en(a_wr_en), .mem_wr_addr(a_wr_addr), .mem_wr_data(a_wr_data),
        .min_dist(a_min), .max_dist(a_max),
        .min_i(a_mi), .min_j(a_mj), .max_i(a_xi), .max_j(a_xj)
    );

    // ---------------- DUT B: 32-bit words, 8 deep ----------------
    logic       b_start, b_busy, b_done, b_wr_en;
    logic [7:0] b_base, b_res, b_rd_addr, b_rd_data, b_wr_addr, b_wr_data;
    logic [3:0] b_count;
    logic [5:0] b_min, b_max;
    logic [2:0] b_mi, b_mj, b_xi, b_xj;

    hamming_minmax_engine #(.WORD_W(32), .N_MAX(8)) dut_b (
        .clk(clk), .reset(reset), .start(b_start),
        .cfg_base(b_base), .cfg_count(b_count), .cfg_res(b_res),
        .busy(b_busy), .done(b_done),
        .mem_rd_addr(b_rd_addr), .mem_rd_data(b_rd_data),
        .mem_wr_en(b_wr_en), .mem_wr_addr(b_wr_addr), .mem_wr_data(b_wr_data),
        .min_dist(b_min), .max_dist(b_max),
        .min_i(b_mi), .min_j(b_mj), .max_i(b_xi), .max_j(b_xj)
    );

    // Source memories are read-only to the DUTs; writes go to a log.
    logic [7:0] mema [256];
    logic [7:0] memb [256];
    logic [7:0] a_wlog_a [1024], a_wlog_d [1024];
    logic [7:0] b_wlog_a [1024], b_wlog_d [1024];
    int a_wr_seen = 0, b_wr_seen = 0;

    always @(posedge clk) begin
        a_rd_data <= mema[a_rd_addr];
        b_rd_data <= memb[b_rd_addr];
        if (a_wr_en) begin
            a_wlog_a[a_wr_seen[9:0]] <= a_wr_addr;
            a_wlog_d[a_wr_seen[9:0]] <= a_wr_data;
            a_wr_seen++;
        end
        if (b_wr_en) begin
            b_wlog_a[b_wr_seen[9:0]] <= b_wr_addr;
            b_wlog_d[b_wr_seen[9:0]] <= b_wr_data;
            b_wr_seen++;
        end
    end

    // Expected results for the run in flight on each DUT.
    bit a_exp_ok = 0, b_exp_ok = 0;
    int ea_mn, ea_mx, ea_mi, ea_mj, ea_xi, ea_xj;
    int eb_mn, eb_mx, eb_mi, eb_mj, eb_xi, eb_xj;

    // Reference: build the word list, scan every pair, keep first strict best.
    task automatic model(input int sel, input int base, input int cnt, input int nb,
                         output int mn, output int mx, output int mi, output int mj,
                         output int xi, output int xj);
        longint unsigned w[$];
        longint unsigned v;
        int d;
        mn = nb * 8; mx = 0; mi = 0; mj = 0; xi = 0; xj = 0;
        for (int k = 0; k < cnt; k++) begin
            v = 0;
            for (int b = 0; b < nb; b++)
                v = (v << 8) | longint'(sel == 0 ? mema[8'(base + nb*k + b)]
                                                 : memb[8'(base + nb*k + b)]);
            w.push_back(v);
        end
        for (int i = 0; i < cnt; i++)
            for (int j = i + 1; j < cnt; j++) begin
                d = $countones(w[i] ^ w[j]);
                if (d < mn) begin mn = d; mi = i; mj = j; end
                if (d > mx) begin mx = d; xi = i; xj = j; end
            end
    endtask

    // Compare process: whenever a run is complete the held results must match.
    always @(negedge clk) begin
        if (a_exp_ok && a_done) begin
            chk("a_min_dist", int'(a_min), ea_mn);
            chk("a_max_dist", int'(a_max), ea_mx);
            chk("a_min_i", int'(a_mi), ea_mi);
            chk("a_min_j", int'(a_mj), ea_mj);
            chk("a_max_i", int'(a_xi), ea_xi);
            chk("a_max_j", int'(a_xj), ea_xj);
            chk("a_rd_addr_idle", int'(a_rd_addr), 0);
        end
        if (b_exp_ok && b_done) begin
            chk("b_min_dist", int'(b_min), eb_mn);
            chk("b_max_dist", int'(b_max), eb_mx);
            chk("b_min_i", int'(b_mi), eb_mi);
            chk("b_min_j", int'(b_mj), eb_mj);
            chk("b_max_i", int'(b_xi), eb_xi);
            chk("b_max_j", int'(b_xj), eb_xj);
            chk("b_rd_addr_idle", int'(b_rd_addr), 0);
        end
    end

    // One run on DUT A. poke_at: cycle to pulse a stray start; rst_at: cycle to
    // pull reset low (both -1 when unused).
    task automatic run_a(input int base, input int cnt_req, input int res,
                         input int poke_at, input int rst_at, input string tag);
        int c, exp_lat, cyc, w0;
        bit aborted;
        a_exp_ok = 0;
        c = (cnt_req > 32) ? 32 : cnt_req;
        model(0, base, c, 2, ea_mn, ea_mx, ea_mi, ea_mj, ea_xi, ea_xj);
        exp_lat = 2*c + 1 + c*(c-1)/2 + 3;
        @(negedge clk);
        a_start = 1; a_base = 8'(base); a_count = 6'(cnt_req); a_res = 8'(res);
        w0 = a_wr_seen;
        @(posedge clk); #1;
        a_start = 0; a_base = 8'($urandom); a_count = 6'($urandom_range(0, 32)); a_res = 8'($urandom);
        chk({tag, "_busy"}, int'(a_busy), 1);
        chk({tag, "_done_clr"}, int'(a_done), 0);
        a_exp_ok = 1;
        cyc = 1; aborted = 0;
        while (!a_done && !aborted && cyc < 5000) begin
            if (cyc == poke_at) begin
                a_start = 1; a_base = 8'hA0; a_count = 6'd3; a_res = 8'h11;
            end
            if (cyc == rst_at) begin
                a_exp_ok = 0;
                #3 reset = 0;
                #1;
                chk({tag, "_rst_busy"}, int'(a_busy), 0);
                chk({tag, "_rst_done"}, int'(a_done), 0);
                chk({tag, "_rst_wr_en"}, int'(a_wr_en), 0);
                chk({tag, "_rst_min"}, int'(a_min), 16);
                @(negedge clk);
                reset = 1;
                aborted = 1;
            end else begin
                @(posedge clk); #1;
                a_start = 0;
                cyc++;
            end
        end
        if (aborted) begin
            repeat (4) @(posedge clk);
            #1;
            chk({tag, "_no_writes"}, a_wr_seen - w0, 0);
            chk({tag, "_idle_busy"}, int'(a_busy), 0);
        end else begin
            chk({tag, "_latency"}, cyc, exp_lat);
            chk({tag, "_nwrites"}, a_wr_seen - w0, 2);
            chk({tag, "_wr0_addr"}, int'(a_wlog_a[w0[9:0]]), res & 255);
            chk({tag, "_wr0_data"}, int'(a_wlog_d[w0[9:0]]), ea_mn);
            chk({tag, "_wr1_addr"}, int'(a_wlog_a[10'(w0 + 1)]), (res + 1) & 255);
            chk({tag, "_wr1_data"}, int'(a_wlog_d[10'(w0 + 1)]), ea_mx);
        end
    endtask

    task automatic run_b(input int base, input int cnt_req, input int res, input string tag);
        int c, exp_lat, cyc, w0;
        b_exp_ok = 0;
        c = (cnt_req > 8) ? 8 : cnt_req;
        model(1, base, c, 4, eb_mn, eb_mx, eb_mi, eb_mj, eb_xi, eb_xj);
        exp_lat = 4*c + 1 + c*(c-1)/2 + 3;
        @(negedge clk);
        b_start = 1; b_base = 8'(base); b_count = 4'(cnt_req); b_res = 8'(res);
        w0 = b_wr_seen;
        @(posedge clk); #1;
        b_start = 0; b_base = 8'($urandom); b_count = 4'($urandom_range(0, 8)); b_res = 8'($urandom);
        chk({tag, "_done_clr"}, int'(b_done), 0);
        b_exp_ok = 1;
        cyc = 1;
        while (!b_done && cyc < 5000) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, "_latency"}, cyc, exp_lat);
        chk({tag, "_nwrites"}, b_wr_seen - w0, 2);
        chk({tag, "_wr0_addr"}, int'(b_wlog_a[w0[9:0]]), res & 255);
        chk({tag, "_wr0_data"}, int'(b_wlog_d[w0[9:0]]), eb_mn);
        chk({tag, "_wr1_addr"}, int'(b_wlog_a[10'(w0 + 1)]), (res + 1) & 255);
        chk({tag, "_wr1_data"}, int'(b_wlog_d[10'(w0 + 1)]), eb_mx);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected summary");
        $fatal(1, "watchdog");
    end

    initial begin
        a_start = 0; a_base = 0; a_count = 0; a_res = 0;
        b_start = 0; b_base = 0; b_count = 0; b_res = 0;
        for (int k = 0; k < 256; k++) begin
            mema[k] = 8'($urandom);
            memb[k] = 8'($urandom);
        end

        // Reset state
        #2 reset = 0;
        #1;
        chk("rst_a_busy", int'(a_busy), 0);
        chk("rst_a_done", int'(a_done), 0);
        chk("rst_a_min", int'(a_min), 16);
        chk("rst_a_max", int'(a_max), 0);
        chk("rst_a_idx", int'({a_mi, a_mj, a_xi, a_xj}), 0);
        chk("rst_a_rd_addr", int'(a_rd_addr), 0);
        chk("rst_a_wr_en", int'(a_wr_en), 0);
        chk("rst_b_min", int'(b_min), 32);
        chk("rst_b_done", int'(b_done), 0);
        @(negedge clk);
        reset = 1;

        // 1: full random run
        run_a(0, 32, 64, -1, -1, "t1");

        // 2: fixed words with ties
        mema[100] = 8'h00; mema[101] = 8'h00;
        mema[102] = 8'hFF; mema[103] = 8'hFF;
        mema[104] = 8'h00; mema[105] = 8'hFF;
        mema[106] = 8'h00; mema[107] = 8'h00;
        run_a(100, 4, 200, -1, -1, "t2");
        chk("t2_min_lit", int'(a_min), 0);
        chk("t2_min_i_lit", int'(a_mi), 0);
        chk("t2_min_j_lit", int'(a_mj), 3);
        chk("t2_max_lit", int'(a_max), 16);
        chk("t2_max_i_lit", int'(a_xi), 0);
        chk("t2_max_j_lit", int'(a_xj), 1);

        // 3: degenerate counts
        run_a(120, 1, 210, -1, -1, "t3c1");
        chk("t3c1_min_lit", int'(a_min), 16);
        chk("t3c1_max_lit", int'(a_max), 0);
        run_a(120, 0, 212, -1, -1, "t3c0");
        chk("t3c0_min_lit", int'(a_min), 16);
        chk("t3c0_max_lit", int'(a_max), 0);

        // 4: stray start during CMP, then reset mid-CMP
        run_a(0, 32, 64, 85, -1, "t4poke");
        run_a(0, 32, 64, -1, 80, "t4rst");
        chk("t4_after_rst_min", int'(a_min), 16);

        // 5: wide words, wrapping base
        run_b(248, 4, 64, "t5");
        run_b(int'($urandom_range(0, 255)), 8, int'($urandom_range(0, 255)), "t5r");
        run_b(int'($urandom_range(0, 255)), 12, 30, "t5clamp");

        // 6: back-to-back, first run forced to min 0, second on fresh data
        mema[32] = mema[30]; mema[33] = mema[31];
        run_a(30, 10, 70, -1, -1, "t6a");
        for (int k = 140; k < 164; k++) mema[k] = 8'($urandom);
        run_a(140, 12, 90, -1, -1, "t6b");

        // Clamp and random configurations
        run_a(0, 40, 64, -1, -1, "clamp");
        for (int it = 0; it < 4; it++)
            run_a(int'($urandom_range(0, 255)), int'($urandom_range(0, 32)),
                  int'($urandom_range(0, 255)), -1, -1, "rnd");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
